// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the datapath and a
// variable-latency request/acknowledge memory port.
// Optional feature macro: DMEM_TIMEOUT_EN (BUSY timeout with abort).
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        align_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  logic   req;
  logic   aligned;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("dmem_ctrl: TIMEOUT must be in 1..65535");
  end

  assign req     = memread | memwrite;
  assign aligned = (aluout[1:0] == 2'b00);

  // Freeze the pipeline from the request cycle until the access retires in DONE
  assign stall = ((state == IDLE) && req && aligned) || (state == BUSY);

`ifdef DMEM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt;

  // Transaction FSM with BUSY-cycle timeout; an ack on the limit cycle wins
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      readdata    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (aligned) begin
              mem_addr  <= aluout[31:2];
              mem_wdata <= writedata;
              mem_we    <= memwrite;
              mem_req   <= 1'b1;
              cnt       <= '0;
              state     <= BUSY;
            end else begin
              align_err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!mem_we) readdata <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (cnt == TO_LAST) begin
            if (!mem_we) readdata <= 32'hDEADBEEF;
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign timeout_err = 1'b0;

  // Transaction FSM; BUSY waits for the memory ack indefinitely
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      readdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (aligned) begin
              mem_addr  <= aluout[31:2];
              mem_wdata <= writedata;
              mem_we    <= memwrite;
              mem_req   <= 1'b1;
              state     <= BUSY;
            end else begin
              align_err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!mem_we) readdata <= mem_rdata;
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl.
module tb_dmem_ctrl;
  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        align_err;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  dmem_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .aluout(aluout), .writedata(writedata), .readdata(readdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .align_err(align_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; aluout = '0;
    writedata = '0; mem_rdata = '0; mem_ack = 1'b0;
    step(); step();
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_readdata: got %h want %h", readdata, 32'h0); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== 30'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    total++; if (align_err !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rst_errs: got %b%b want 00", align_err, timeout_err); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (stall !== 1'b0 || mem_req !== 1'b0 || readdata !== 32'h0) begin
        bad++;
        $display("FAIL idle_quiet[%0d]: got stall=%b req=%b rd=%h want 0 0 0", i, stall, mem_req, readdata);
      end
    end
  endtask

  task automatic test_load();
    aluout = 32'h0000_0010; memread = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall_idle: got %b want 1", stall); end
    step(); // BUSY
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL load_req: got %b want 1", mem_req); end
    total++; if (mem_addr !== 30'h4) begin bad++; $display("FAIL load_addr: got %h want 4", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL load_we: got %b want 0", mem_we); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_stall_busy: got %b want 1", stall); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step(); // DONE
    mem_ack = 1'b0; mem_rdata = '0; #1;
    total++; if (readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL load_data: got %h want cafef00d", readdata); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL load_req_done: got %b want 0", mem_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_stall_done: got %b want 0", stall); end
    memread = 1'b0;
    step(); // IDLE
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL load_retrigger: got req=%b stall=%b want 0 0", mem_req, stall); end
  endtask

  task automatic test_store();
    aluout = 32'h20; writedata = 32'h1234_5678; memwrite = 1'b1;
    step(); // BUSY 1
    writedata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 30'h8 || stall !== 1'b1) begin
        bad++;
        $display("FAIL store_busy[%0d]: got req=%b we=%b wd=%h a=%h st=%b want 1 1 12345678 8 1",
                 i, mem_req, mem_we, mem_wdata, mem_addr, stall);
      end
      if (i == 4) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0; #1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL store_done: got req=%b stall=%b want 0 0", mem_req, stall); end
    total++; if (readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL store_readdata: got %h want cafef00d", readdata); end
    memwrite = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    aluout = 32'h0000_0013; memread = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mis_stall: got %b want 0", stall); end
    step();
    memread = 1'b0;
    total++; if (align_err !== 1'b1) begin bad++; $display("FAIL mis_err_pulse: got %b want 1", align_err); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_req: got %b want 0", mem_req); end
    step();
    total++; if (align_err !== 1'b0) begin bad++; $display("FAIL mis_err_clear: got %b want 0", align_err); end
    total++; if (mem_req !== 1'b0 || readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL mis_after: got req=%b rd=%h want 0 cafef00d", mem_req, readdata); end
  endtask

  task automatic test_both_strobes();
    aluout = 32'h40; writedata = 32'hAABB_CCDD; memread = 1'b1; memwrite = 1'b1;
    step(); // BUSY
    total++; if (mem_we !== 1'b1 || mem_addr !== 30'h10 || mem_wdata !== 32'hAABB_CCDD) begin
      bad++; $display("FAIL both_store: got we=%b a=%h wd=%h want 1 10 aabbccdd", mem_we, mem_addr, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step(); // DONE
    mem_ack = 1'b0; memread = 1'b0; memwrite = 1'b0;
    total++; if (readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL both_readdata: got %h want cafef00d", readdata); end
    step();
  endtask

  task automatic test_back_to_back();
    aluout = 32'h100; memread = 1'b1;
    step(); // BUSY
    total++; if (mem_addr !== 30'h40) begin bad++; $display("FAIL b2b_addr_a: got %h want 40", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_000A;
    step(); // DONE
    mem_ack = 1'b0; aluout = 32'h104; #1;
    total++; if (readdata !== 32'hA || stall !== 1'b0) begin bad++; $display("FAIL b2b_done_a: got rd=%h st=%b want a 0", readdata, stall); end
    step(); // IDLE, second request
    total++; if (stall !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL b2b_idle_b: got st=%b req=%b want 1 0", stall, mem_req); end
    step(); // BUSY
    total++; if (mem_req !== 1'b1 || mem_addr !== 30'h41) begin bad++; $display("FAIL b2b_busy_b: got req=%b a=%h want 1 41", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_000B;
    step(); // DONE
    mem_ack = 1'b0; memread = 1'b0; #1;
    total++; if (readdata !== 32'hB || stall !== 1'b0) begin bad++; $display("FAIL b2b_done_b: got rd=%h st=%b want b 0", readdata, stall); end
    step();
  endtask

  task automatic test_reset_busy();
    aluout = 32'h30; memread = 1'b1;
    step(); // BUSY
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rb_req_busy: got %b want 1", mem_req); end
    reset = 1'b1; memread = 1'b0;
    step();
    total++; if (mem_req !== 1'b0 || readdata !== 32'h0 || stall !== 1'b0) begin
      bad++; $display("FAIL rb_reset: got req=%b rd=%h st=%b want 0 0 0", mem_req, readdata, stall); end
    reset = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0 || readdata !== 32'h0 || stall !== 1'b0) begin
      bad++; $display("FAIL rb_late_ack: got req=%b rd=%h st=%b want 0 0 0", mem_req, readdata, stall); end
    step();
    total++; if (mem_req !== 1'b0 || readdata !== 32'h0) begin
      bad++; $display("FAIL rb_after: got req=%b rd=%h want 0 0", mem_req, readdata); end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    aluout = 32'h50; memread = 1'b1;
    step(); // BUSY 1
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem_req !== 1'b1 || timeout_err !== 1'b0 || stall !== 1'b1) begin
        bad++; $display("FAIL to_busy[%0d]: got req=%b te=%b st=%b want 1 0 1", i, mem_req, timeout_err, stall);
      end
      step();
    end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_pulse: got %b want 1", timeout_err); end
    total++; if (readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL to_readdata: got %h want deadbeef", readdata); end
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL to_done: got req=%b st=%b want 0 0", mem_req, stall); end
    memread = 1'b0;
    step();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", timeout_err); end
  endtask
`else
  task automatic test_no_timeout();
    aluout = 32'h50; memread = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      total++;
      if (mem_req !== 1'b1 || timeout_err !== 1'b0 || stall !== 1'b1) begin
        bad++; $display("FAIL nto_busy[%0d]: got req=%b te=%b st=%b want 1 0 1", i, mem_req, timeout_err, stall);
      end
      step();
    end
    mem_ack = 1'b1; mem_rdata = 32'h7777_0000;
    step();
    mem_ack = 1'b0; memread = 1'b0;
    total++; if (readdata !== 32'h7777_0000 || mem_req !== 1'b0) begin
      bad++; $display("FAIL nto_done: got rd=%h req=%b want 77770000 0", readdata, mem_req); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_both_strobes();
    test_back_to_back();
    test_reset_busy();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
